// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-port data-memory arbiter: size codes, FSM states,
// port identifiers and the access-size legality check.
package dmem_arb_pkg;

    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef logic port_id_t;

    function automatic logic size_legal(input logic [2:0] size);
        return (size == SB) || (size == SH) || (size == SW);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester-side data-memory port: request handshake plus response pulse.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              req_lock;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, req_lock,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, req_lock,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-request round-robin picker; ptr names the port that wins a tie.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with atomic lock sequences, a lock timeout and a
// two-stage pipeline (S1 drives the memory, S2 returns the response).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int LOCK_MAX = 16,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    dmem_arbiter_if.slave     p0,
    dmem_arbiter_if.slave     p1,
    output logic              mem_we,
    output logic              mem_re,
    output logic [2:0]        mem_func3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    arb_state_t state, state_n;
    port_id_t   ptr, owner, owner_n;
    logic [7:0] lock_cnt, lock_cnt_n;

    logic [1:0]        req_vec, elig, gnt;
    logic              grant_any, timeout, inject, tag;
    port_id_t          gport;
    logic              g_we, g_lock;
    logic [2:0]        g_size;
    logic [ADDR_W-1:0] g_addr;
    logic [31:0]       g_wdata;

    logic              s1_valid, s1_we, s1_memop, s1_err;
    port_id_t          s1_port;
    logic [2:0]        s1_size;
    logic [ADDR_W-1:0] s1_addr;
    logic [31:0]       s1_wdata;

    logic              s2_valid, s2_err;
    port_id_t          s2_port;
    logic [31:0]       s2_rdata;

    assign req_vec = {p1.req_valid, p0.req_valid};
    assign timeout = (state == LOCKED) && (lock_cnt == 8'(LOCK_MAX));

    // While locked only the owner is eligible, and nobody once the lock expires.
    always_comb begin
        elig = 2'b00;
        if (!reset) begin
            if (state == ARB) begin
                elig = req_vec;
            end else if (!timeout) begin
                elig = owner ? {req_vec[1], 1'b0} : {1'b0, req_vec[0]};
            end
        end
    end

    rr_arb2 u_pick (
        .req (elig),
        .ptr (ptr),
        .gnt (gnt)
    );

    assign p0.req_ready = gnt[0];
    assign p1.req_ready = gnt[1];
    assign grant_any    = |gnt;
    assign gport        = gnt[1];

    assign g_we    = gport ? p1.req_we    : p0.req_we;
    assign g_lock  = gport ? p1.req_lock  : p0.req_lock;
    assign g_size  = gport ? p1.req_size  : p0.req_size;
    assign g_addr  = gport ? p1.req_addr  : p0.req_addr;
    assign g_wdata = gport ? p1.req_wdata : p0.req_wdata;

    always_comb begin
        state_n    = state;
        owner_n    = owner;
        lock_cnt_n = lock_cnt;
        case (state)
            ARB: begin
                if (grant_any && g_lock) begin
                    state_n    = LOCKED;
                    owner_n    = gport;
                    lock_cnt_n = 8'd1;
                end
            end
            LOCKED: begin
                if (timeout || (grant_any && !g_lock)) begin
                    state_n    = ARB;
                    lock_cnt_n = 8'd0;
                end else begin
                    lock_cnt_n = lock_cnt + 8'd1;
                end
            end
            default: state_n = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB;
            ptr      <= 1'b0;
            owner    <= 1'b0;
            lock_cnt <= 8'd0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            lock_cnt <= lock_cnt_n;
            if (grant_any) begin
                ptr <= ~gport;
            end
        end
    end

    // On timeout the owner's in-flight S1 entry carries the error; with nothing
    // in flight a standalone error pulse is injected into the free S1 slot.
    assign tag    = timeout && s1_valid && (s1_port == owner);
    assign inject = timeout && !tag;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_port  <= 1'b0;
            s1_we    <= 1'b0;
            s1_memop <= 1'b0;
            s1_err   <= 1'b0;
            s1_size  <= 3'b000;
            s1_addr  <= '0;
            s1_wdata <= 32'h0;
            s2_valid <= 1'b0;
            s2_port  <= 1'b0;
            s2_err   <= 1'b0;
            s2_rdata <= 32'h0;
        end else begin
            s1_valid <= grant_any || inject;
            if (grant_any) begin
                s1_port  <= gport;
                s1_we    <= g_we;
                s1_size  <= g_size;
                s1_addr  <= g_addr;
                s1_wdata <= g_wdata;
                s1_memop <= size_legal(g_size);
                s1_err   <= !size_legal(g_size);
            end else if (inject) begin
                s1_port  <= owner;
                s1_memop <= 1'b0;
                s1_err   <= 1'b1;
            end
            s2_valid <= s1_valid;
            s2_port  <= s1_port;
            s2_err   <= s1_err || tag;
            s2_rdata <= (s1_valid && s1_memop && !s1_we && !tag) ? mem_rdata : 32'h0;
        end
    end

    assign mem_we    = !reset && s1_valid && s1_memop && s1_we;
    assign mem_re    = !reset && s1_valid && s1_memop && !s1_we;
    assign mem_func3 = s1_size;
    assign mem_addr  = s1_addr;
    assign mem_wdata = s1_wdata;

    assign p0.resp_valid = !reset && s2_valid && (s2_port == 1'b0);
    assign p1.resp_valid = !reset && s2_valid && (s2_port == 1'b1);
    assign p0.resp_err   = p0.resp_valid && s2_err;
    assign p1.resp_err   = p1.resp_valid && s2_err;
    assign p0.resp_rdata = p0.resp_valid ? s2_rdata : 32'h0;
    assign p1.resp_rdata = p1.resp_valid ? s2_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed memory model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk;
    logic        reset;
    logic        mem_we, mem_re;
    logic [2:0]  mem_func3;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [16];

    int vectors     = 0;
    int miscompares = 0;
    int err_pulses  = 0;

    dmem_arbiter_if #(.ADDR_W(32)) p0_if ();
    dmem_arbiter_if #(.ADDR_W(32)) p1_if ();

    dmem_arbiter #(.LOCK_MAX(4), .ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .p0        (p0_if),
        .p1        (p1_if),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_func3 (mem_func3),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mem_rdata = mem[mem_addr[5:2]];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
        end else if (mem_we) begin
            mem[mem_addr[5:2]] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input int p, input logic v, input logic we, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] d, input logic lk);
        if (p == 0) begin
            p0_if.req_valid = v; p0_if.req_we = we; p0_if.req_size = sz;
            p0_if.req_addr = a;  p0_if.req_wdata = d; p0_if.req_lock = lk;
        end else begin
            p1_if.req_valid = v; p1_if.req_we = we; p1_if.req_size = sz;
            p1_if.req_addr = a;  p1_if.req_wdata = d; p1_if.req_lock = lk;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req(0, 1'b1, 1'b1, SW, 32'h10, 32'h1234, 1'b0);
        req(1, 1'b1, 1'b0, SW, 32'h10, 32'h0, 1'b0);
        tick(); tick();
        #2;
        chk("rst_p0_ready", p0_if.req_ready, 1'b0);
        chk("rst_p1_ready", p1_if.req_ready, 1'b0);
        chk("rst_p0_resp",  p0_if.resp_valid, 1'b0);
        chk("rst_p1_resp",  p1_if.resp_valid, 1'b0);
        chk("rst_mem_we",   mem_we, 1'b0);
        chk("rst_mem_re",   mem_re, 1'b0);

        // store then load to the same address
        tick(); reset = 1'b0;
        req(1, 1'b0, 1'b0, SW, 32'h0, 32'h0, 1'b0);
        req(0, 1'b1, 1'b1, SW, 32'h10, 32'hDEADBEEF, 1'b0);
        #2 chk("st_ready", p0_if.req_ready, 1'b1);
        tick(); req(0, 1'b1, 1'b0, SW, 32'h10, 32'h0, 1'b0);
        #2;
        chk("ld_ready", p0_if.req_ready, 1'b1);
        chk("st_mem_we", mem_we, 1'b1);
        chk("st_mem_addr", mem_addr, 32'h10);
        chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
        tick(); req(0, 1'b0, 1'b0, SW, 32'h0, 32'h0, 1'b0);
        #2;
        chk("st_resp_valid", p0_if.resp_valid, 1'b1);
        chk("st_resp_rdata", p0_if.resp_rdata, 32'h0);
        chk("ld_mem_re", mem_re, 1'b1);
        tick(); #2;
        chk("ld_resp_valid", p0_if.resp_valid, 1'b1);
        chk("ld_resp_rdata", p0_if.resp_rdata, 32'hDEADBEEF);
        chk("ld_resp_err", p0_if.resp_err, 1'b0);
        chk("ld_p1_quiet", p1_if.resp_valid, 1'b0);

        // p1 alone reads the same word
        tick(); req(1, 1'b1, 1'b0, SW, 32'h10, 32'h0, 1'b0);
        #2 chk("p1_ready", p1_if.req_ready, 1'b1);
        tick(); req(1, 1'b0, 1'b0, SW, 32'h0, 32'h0, 1'b0);
        tick(); #2;
        chk("p1_resp_valid", p1_if.resp_valid, 1'b1);
        chk("p1_resp_rdata", p1_if.resp_rdata, 32'hDEADBEEF);
        chk("p1_p0_quiet", p0_if.resp_valid, 1'b0);

        // both ports valid: grants and responses alternate p0,p1,p0,p1
        tick();
        req(0, 1'b1, 1'b1, SW, 32'h20, 32'h11111111, 1'b0);
        req(1, 1'b1, 1'b0, SW, 32'h10, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                req(0, 1'b0, 1'b0, SW, 32'h0, 32'h0, 1'b0);
                req(1, 1'b0, 1'b0, SW, 32'h0, 32'h0, 1'b0);
            end
            #2;
            if (i < 4) begin
                chk("rr_p0_ready", p0_if.req_ready, (i % 2) == 0);
                chk("rr_p1_ready", p1_if.req_ready, (i % 2) == 1);
            end
            if (i >= 2) begin
                chk("rr_p0_resp", p0_if.resp_valid, (i % 2) == 0);
                chk("rr_p1_resp", p1_if.resp_valid, (i % 2) == 1);
                chk("rr_rdata", p0_if.resp_rdata | p1_if.resp_rdata,
                    ((i % 2) == 1) ? 32'hDEADBEEF : 32'h0);
            end
            tick();
        end

        // p1 lock sequence blocks p0 until after the unlocking grant
        req(1, 1'b1, 1'b0, SW, 32'h10, 32'h0, 1'b1);
        #2 chk("lk_c0_p1_ready", p1_if.req_ready, 1'b1);
        tick(); req(0, 1'b1, 1'b0, SW, 32'h20, 32'h0, 1'b0);
        #2;
        chk("lk_c1_p0_ready", p0_if.req_ready, 1'b0);
        chk("lk_c1_p1_ready", p1_if.req_ready, 1'b1);
        tick(); req(1, 1'b1, 1'b0, SW, 32'h10, 32'h0, 1'b0);
        #2;
        chk("lk_c2_p0_ready", p0_if.req_ready, 1'b0);
        chk("lk_c2_p1_ready", p1_if.req_ready, 1'b1);
        chk("lk_c2_p1_resp", p1_if.resp_rdata, 32'hDEADBEEF);
        tick(); req(1, 1'b0, 1'b0, SW, 32'h0, 32'h0, 1'b0);
        #2;
        chk("lk_c3_p0_ready", p0_if.req_ready, 1'b1);
        chk("lk_c3_p1_resp", p1_if.resp_valid, 1'b1);
        tick(); req(0, 1'b0, 1'b0, SW, 32'h0, 32'h0, 1'b0);
        #2 chk("lk_c4_p1_resp", p1_if.resp_valid, 1'b1);
        tick(); #2;
        chk("lk_c5_p0_resp", p0_if.resp_valid, 1'b1);
        chk("lk_c5_p0_rdata", p0_if.resp_rdata, 32'h11111111);

        // p0 holds lock past LOCK_MAX=4: forced release, p1 wins, one error
        tick(); req(0, 1'b1, 1'b0, SW, 32'h20, 32'h0, 1'b1);
        #2 chk("to_d0_p0_ready", p0_if.req_ready, 1'b1);
        tick(); req(1, 1'b1, 1'b0, SW, 32'h10, 32'h0, 1'b0);
        #2;
        chk("to_d1_p0_ready", p0_if.req_ready, 1'b1);
        chk("to_d1_p1_ready", p1_if.req_ready, 1'b0);
        for (int d = 2; d <= 6; d++) begin
            tick();
            if (d == 6) begin
                req(0, 1'b0, 1'b0, SW, 32'h0, 32'h0, 1'b0);
                req(1, 1'b0, 1'b0, SW, 32'h0, 32'h0, 1'b0);
            end
            #2;
            if (d <= 5) begin
                chk("to_p0_ready", p0_if.req_ready, d <= 3);
                chk("to_p1_ready", p1_if.req_ready, d == 5);
                chk("to_p0_resp", p0_if.resp_valid, 1'b1);
                chk("to_p0_rdata", p0_if.resp_rdata, (d == 5) ? 32'h0 : 32'h11111111);
            end else begin
                chk("to_p0_resp_end", p0_if.resp_valid, 1'b0);
            end
            if (p0_if.resp_err) err_pulses++;
        end
        chk("to_err_count", err_pulses, 1);
        tick(); #2;
        chk("to_p1_resp", p1_if.resp_valid, 1'b1);
        chk("to_p1_err", p1_if.resp_err, 1'b0);

        // illegal size 011
        tick(); req(0, 1'b1, 1'b1, 3'b011, 32'h30, 32'h55, 1'b0);
        #2 chk("bad_ready", p0_if.req_ready, 1'b1);
        tick(); req(0, 1'b0, 1'b0, SW, 32'h0, 32'h0, 1'b0);
        #2;
        chk("bad_mem_we", mem_we, 1'b0);
        chk("bad_mem_re", mem_re, 1'b0);
        tick(); #2;
        chk("bad_resp_valid", p0_if.resp_valid, 1'b1);
        chk("bad_resp_err", p0_if.resp_err, 1'b1);
        chk("bad_resp_rdata", p0_if.resp_rdata, 32'h0);

        // reset one cycle after an accept drops it
        tick(); req(0, 1'b1, 1'b1, SW, 32'h30, 32'h77, 1'b0);
        #2 chk("mr_ready", p0_if.req_ready, 1'b1);
        tick(); req(0, 1'b0, 1'b0, SW, 32'h0, 32'h0, 1'b0); reset = 1'b1;
        #2 chk("mr_mem_we", mem_we, 1'b0);
        tick(); reset = 1'b0;
        #2;
        chk("mr_p0_resp_a", p0_if.resp_valid, 1'b0);
        chk("mr_p1_resp_a", p1_if.resp_valid, 1'b0);
        tick();
        req(0, 1'b1, 1'b0, SW, 32'h10, 32'h0, 1'b0);
        req(1, 1'b1, 1'b0, SW, 32'h10, 32'h0, 1'b0);
        #2;
        chk("mr_p0_resp_b", p0_if.resp_valid, 1'b0);
        chk("mr_p1_resp_b", p1_if.resp_valid, 1'b0);
        chk("mr_tie_p0", p0_if.req_ready, 1'b1);
        chk("mr_tie_p1", p1_if.req_ready, 1'b0);
        tick();
        req(0, 1'b0, 1'b0, SW, 32'h0, 32'h0, 1'b0);
        req(1, 1'b0, 1'b0, SW, 32'h0, 32'h0, 1'b0);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
